// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and elaboration helpers for the round-robin FIFO read scheduler.
// The optional word-count grant threshold is enabled by FIFO_RD_SCHED_THRESH_EN.
package fifo_rd_sched_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  localparam int unsigned MinPorts = 2;
  localparam int unsigned MaxPorts = 16;
  localparam int unsigned MaxBurstLimit = 256;

  // Index width needed to address n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the search starts
// just past the last winner, priority-encode, then un-rotate back to a port index.
module fifo_rd_sched_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] pick
);

  logic [N-1:0] rot;
  int unsigned  enc;
  int unsigned  src;
  int unsigned  dst;
  logic         found;

  always_comb begin
    rot   = '0;
    enc   = 0;
    src   = 0;
    dst   = 0;
    found = 1'b0;
    any   = |req;

    for (int i = 0; i < int'(N); i++) begin
      src    = (32'(last) + 32'd1 + 32'(i)) % N;
      rot[i] = req[src[W-1:0]];
    end

    for (int i = 0; i < int'(N); i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        enc   = 32'(i);
      end
    end

    dst  = (32'(last) + 32'd1 + enc) % N;
    pick = dst[W-1:0];
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Round-robin read scheduler draining N_PORTS FIFOs into one valid/ready channel.
// Define FIFO_RD_SCHED_THRESH_EN to require MIN_WORDS buffered words before a grant.
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int unsigned N_PORTS     = 4,
  parameter int unsigned N_PORTS_log = 2,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned BURST_log   = 3,
  parameter int unsigned N_log       = 8,
  parameter int unsigned MIN_WORDS   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PORTS-1:0]           i_port_en,
  input  logic [N_PORTS-1:0]           i_empty,
  input  logic [N_PORTS*(N_log+1)-1:0] i_words,
  output logic [N_PORTS-1:0]           o_advance,
  output logic [N_PORTS_log-1:0]       o_sel,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy
);

  localparam int unsigned WordW = N_log + 1;
  localparam logic [BURST_log-1:0] LastBeat = BURST_log'(MAX_BURST - 1);

  if (N_PORTS < MinPorts || N_PORTS > MaxPorts) begin : g_bad_ports
    $error("fifo_rd_sched: N_PORTS out of range");
  end
  if (N_PORTS_log != idx_width(N_PORTS)) begin : g_bad_sel_width
    $error("fifo_rd_sched: N_PORTS_log must equal ceil(log2(N_PORTS))");
  end
  if (MAX_BURST < 1 || MAX_BURST > MaxBurstLimit || BURST_log < 1 ||
      (64'd1 << BURST_log) < 64'(MAX_BURST)) begin : g_bad_burst
    $error("fifo_rd_sched: MAX_BURST/BURST_log inconsistent");
  end

  state_e                   state_q, state_d;
  logic [N_PORTS_log-1:0]   sel_q, sel_d;
  logic [N_PORTS_log-1:0]   rr_last_q, rr_last_d;
  logic [BURST_log-1:0]     burst_cnt_q, burst_cnt_d;

  logic [N_PORTS-1:0]       elig;
  logic                     pick_any;
  logic [N_PORTS_log-1:0]   pick_idx;
  logic                     pop;
  logic                     burst_end;

`ifdef FIFO_RD_SCHED_THRESH_EN
  localparam logic [WordW-1:0] MinWordsW = WordW'(MIN_WORDS);

  logic [N_PORTS-1:0] thresh_ok;
  logic [WordW-1:0]   word_cnt;

  // MSB set means the FIFO is full, which always qualifies.
  always_comb begin
    thresh_ok = '0;
    word_cnt  = '0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      word_cnt     = i_words[p*WordW +: WordW];
      thresh_ok[p] = (word_cnt >= MinWordsW) | word_cnt[WordW-1];
    end
  end

  assign elig = i_port_en & ~i_empty & thresh_ok;
`else
  logic unused_words;
  assign unused_words = ^i_words;

  assign elig = i_port_en & ~i_empty;
`endif

  fifo_rd_sched_rr_pick #(
    .N (N_PORTS),
    .W (N_PORTS_log)
  ) u_rr_pick (
    .req  (elig),
    .last (rr_last_q),
    .any  (pick_any),
    .pick (pick_idx)
  );

  // Outputs are decoded from registered state so reset drops them immediately.
  always_comb begin
    o_busy    = (state_q == StBurst);
    o_valid   = o_busy & ~i_empty[sel_q];
    pop       = o_valid & i_ready;
    o_advance = pop ? (N_PORTS'(1) << sel_q) : '0;
    o_sel     = sel_q;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    burst_end   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          sel_d       = pick_idx;
          burst_cnt_d = '0;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        // A pop always completes; disable or empty only release on a non-pop cycle.
        if (pop) begin
          if (burst_cnt_q == LastBeat) begin
            burst_end   = 1'b1;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (i_empty[sel_q] || !i_port_en[sel_q]) begin
          burst_end = 1'b1;
        end

        if (burst_end) begin
          rr_last_d = sel_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      rr_last_q   <= N_PORTS_log'(N_PORTS - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: doc/fifo_rd_sched.md
Name: fifo_rd_sched

Overview:
- Round-robin read-side scheduler that drains N_PORTS independent async FIFOs into one shared downstream valid/ready channel.
- Lives entirely in the read clock domain. Consumes each FIFO's registered empty flag (and, optionally, its word count) and drives each FIFO's read-advance strobe.
- Drives the data-mux select for the shared storage read port.
- Grants one port at a time for a bounded burst, giving fair bandwidth sharing between the FIFOs.

Parameters:
- N_PORTS, 4, number of FIFO read sides served (2..16)
- N_PORTS_log, 2, width of port index; must equal ceil(log2(N_PORTS))
- MAX_BURST, 8, maximum pops per grant (1..256)
- BURST_log, 3, burst counter width; must satisfy 2^BURST_log >= MAX_BURST
- N_log, 8, FIFO pointer bits; per-port word count is N_log+1 bits wide
- MIN_WORDS, 4, grant threshold, used only with the optional feature

Ports:
- clk  in  1  read-side clock
- rst_n  in  1  reset, asynchronous assert, active-low
- i_port_en  in  N_PORTS  per-port scheduling enable
- i_empty  in  N_PORTS  per-port registered empty flag from the FIFO read side
- i_words  in  N_PORTS*(N_log+1)  per-port word count, port p at bits [p*(N_log+1) +: N_log+1]; ignored without the optional feature
- o_advance  out  N_PORTS  per-port read-advance strobe (one-hot or zero)
- o_sel  out  N_PORTS_log  granted port index, drives the data mux
- o_valid  out  1  head word of the granted port is present on the shared channel
- i_ready  in  1  downstream accepts the word this cycle
- o_busy  out  1  a grant is held (state BURST)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, o_sel=0, rr_last=N_PORTS-1, burst_cnt=0, o_valid=0, o_advance=0, o_busy=0.
- Eligibility: elig[p] = i_port_en[p] & ~i_empty[p].
- State IDLE:
  - If elig != 0, pick the first eligible port searching upward from rr_last+1, modulo N_PORTS.
  - Register the pick into o_sel, clear burst_cnt, go to BURST. o_sel is registered.
  - First o_valid is therefore one cycle after elig rises. Minimum latency is 1 cycle.
- State BURST:
  - o_valid = ~i_empty[o_sel] (combinational from a registered flag).
  - o_advance[o_sel] = o_valid & i_ready. All other advance bits are 0. A pop is defined as o_valid & i_ready.
  - On a pop: burst_cnt++.
  - Burst end, evaluated in this priority order:
    (a) pop with burst_cnt == MAX_BURST-1;
    (b) no pop and i_empty[o_sel]=1;
    (c) no pop and i_port_en[o_sel]=0.
  - On burst end: rr_last <= o_sel, state -> IDLE.
  - A grant is never revoked in a cycle with a pop. Disabling a port mid-burst takes effect at the first cycle without a pop.
  - i_empty may rise one cycle late after the last word pops. The FIFO internally gates advance by its own empty flag, so the stale cycle is harmless. The scheduler still holds o_valid=0 whenever i_empty=1.
- IDLE always costs one bubble cycle between bursts. There is no back-to-back regrant.
- A single eligible port is regranted after the bubble.
- o_sel holds its last value in IDLE. o_valid=0 in IDLE.
- o_valid may deassert mid-burst (FIFO momentarily empty) only by ending the burst, per (b).
- burst_cnt saturation: never exceeds MAX_BURST-1. With MAX_BURST=1, every pop ends the burst.
- Simultaneous events: condition (a) wins over (c). A pop in the same cycle as i_port_en falling completes the pop; release happens at the next non-pop cycle.

Optional Feature:
- Macro FIFO_RD_SCHED_THRESH_EN.
- When defined:
  - elig[p] additionally requires i_words[p] >= MIN_WORDS, compared unsigned on N_log+1 bits, or i_words[p] MSB set (full).
  - The threshold gates only the grant. An ongoing burst continues until the normal end conditions.
  - Ports with fewer than MIN_WORDS are skipped until they fill.
- When undefined: i_words is unused (no logic); elig = i_port_en & ~i_empty.

Decomposition:
- Package fifo_rd_sched_pkg:
  - state encoding (IDLE=1'b0, BURST=1'b1);
  - localparam helper for port-index width checks.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: request vector, last index. Outputs: any, pick index.
  - Implemented via rotate, priority-encode, un-rotate.
- The scheduler keeps state, rr_last, burst_cnt and the output decode.

Test Plan:
- Reset mid-burst: port 1 granted, burst_cnt=3, rst_n pulse low -> o_valid/o_advance/o_busy drop immediately; after release, state IDLE, first grant searches from port 0.
- Fairness: all 4 ports non-empty with 20 words, i_ready=1 -> grants 0,1,2,3,0,... each with exactly 8 advances and one idle cycle between bursts.
- Short FIFO: port 2 holds 3 words, others empty -> 3 advances on port 2, then o_valid=0, burst ends, IDLE; no advance pulses while i_empty[2]=1.
- Backpressure: i_ready toggles 1,0,0,1,... during a burst -> o_advance pulses only when i_ready=1; burst_cnt counts pops only; o_sel stable throughout.
- Disable mid-burst: i_port_en[1] falls during a pop cycle -> that pop completes; release happens next cycle with i_ready=0 or on the next non-pop cycle; port 1 is not regranted while disabled.
- Threshold (FIFO_RD_SCHED_THRESH_EN, MIN_WORDS=4): port 0 words=3, port 3 words=5 -> port 3 is granted and port 0 is skipped; port 0 reaches 4 -> granted next round.
